// File: rtl/hamming_corrector_pipeline_if.sv
// Handshake bundle between the Hamming decoder and its neighbours:
// codeword input stream and corrected-data output stream.
interface hamming_corrector_pipeline_if #(
    parameter int DATA_WIDTH = 8
);
    function automatic int calc_parity_width(input int dw);
        int r;
        r = 0;
        for (int p = 1; p < 32; p++) begin
            if (r == 0 && (1 << p) >= dw + p + 1) r = p;
        end
        return r;
    endfunction

    localparam int PARITY_WIDTH = calc_parity_width(DATA_WIDTH);
    localparam int BLOCK_WIDTH  = DATA_WIDTH + PARITY_WIDTH;

    logic [BLOCK_WIDTH-1:0]  in_block;
    logic                    in_valid;
    logic                    in_ready;
    logic [DATA_WIDTH-1:0]   out_data;
    logic [PARITY_WIDTH-1:0] out_syndrome;
    logic                    out_corrected;
    logic                    out_uncorrectable;
    logic                    out_valid;
    logic                    out_ready;

    // Decoder side.
    modport slave (
        input  in_block, in_valid, out_ready,
        output in_ready, out_data, out_syndrome, out_corrected,
               out_uncorrectable, out_valid
    );

    // Upstream producer / downstream consumer side.
    modport master (
        output in_block, in_valid, out_ready,
        input  in_ready, out_data, out_syndrome, out_corrected,
               out_uncorrectable, out_valid
    );
endinterface

// File: rtl/hamming_corrector_pipeline.sv
// Two-stage single-error-correcting Hamming decoder with valid/ready flow
// control and saturating corrected/uncorrectable beat counters.
// Stage 1 registers the codeword with its syndrome; stage 2 registers the
// corrected data and status flags.
module hamming_corrector_pipeline #(
    parameter int DATA_WIDTH    = 8,
    parameter int COUNTER_WIDTH = 16
) (
    input  logic                     clock,
    input  logic                     resetn,
    hamming_corrector_pipeline_if.slave bus,
    input  logic                     count_clear,
    output logic [COUNTER_WIDTH-1:0] corrected_count,
    output logic [COUNTER_WIDTH-1:0] uncorrectable_count
);
    function automatic int calc_parity_width(input int dw);
        int r;
        r = 0;
        for (int p = 1; p < 32; p++) begin
            if (r == 0 && (1 << p) >= dw + p + 1) r = p;
        end
        return r;
    endfunction

    localparam int PARITY_WIDTH = calc_parity_width(DATA_WIDTH);
    localparam int BLOCK_WIDTH  = DATA_WIDTH + PARITY_WIDTH;

    // Syndrome bit i covers every 1-based position with bit i set.
    function automatic logic [PARITY_WIDTH-1:0] calc_syndrome(input logic [BLOCK_WIDTH-1:0] blk);
        logic [PARITY_WIDTH-1:0] s;
        s = '0;
        for (int j = 0; j < BLOCK_WIDTH; j++) begin
            for (int i = 0; i < PARITY_WIDTH; i++) begin
                if (((j + 1) >> i) % 2 == 1) s[i] = s[i] ^ blk[j];
            end
        end
        return s;
    endfunction

    // Data bits occupy the non-power-of-two positions in ascending order.
    function automatic logic [DATA_WIDTH-1:0] extract_data(input logic [BLOCK_WIDTH-1:0] blk);
        logic [DATA_WIDTH-1:0] d;
        int k;
        d = '0;
        k = 0;
        for (int pos = 1; pos <= BLOCK_WIDTH; pos++) begin
            if ((pos & (pos - 1)) != 0) begin
                d[k] = blk[pos-1];
                k++;
            end
        end
        return d;
    endfunction

    logic                     r_s1_valid;
    logic [BLOCK_WIDTH-1:0]   r_s1_block;
    logic [PARITY_WIDTH-1:0]  r_s1_syndrome;

    logic                     r_s2_valid;
    logic [DATA_WIDTH-1:0]    r_out_data;
    logic [PARITY_WIDTH-1:0]  r_out_syndrome;
    logic                     r_out_corrected;
    logic                     r_out_uncorrectable;

    logic [COUNTER_WIDTH-1:0] r_corr_cnt;
    logic [COUNTER_WIDTH-1:0] r_uncorr_cnt;

    logic                     w_s2_en;
    logic                     w_in_ready;
    logic                     w_in_fire;
    logic                     w_out_fire;
    logic                     w_in_range;
    logic                     w_out_of_range;
    logic [BLOCK_WIDTH-1:0]   w_fixed_block;

    // Stage 2 can take a beat when empty or draining; stage 1 likewise
    // frees up when stage 2 advances, so bubbles collapse.
    assign w_s2_en    = !r_s2_valid || bus.out_ready;
    assign w_in_ready = !r_s1_valid || w_s2_en;
    assign w_in_fire  = bus.in_valid && w_in_ready;
    assign w_out_fire = r_s2_valid && bus.out_ready;

    // Flip the bit addressed by an in-range syndrome; out-of-range leaves the block untouched.
    always_comb begin
        w_fixed_block  = r_s1_block;
        w_in_range     = (r_s1_syndrome != '0) && (int'(r_s1_syndrome) <= BLOCK_WIDTH);
        w_out_of_range = int'(r_s1_syndrome) > BLOCK_WIDTH;
        for (int j = 0; j < BLOCK_WIDTH; j++) begin
            if (w_in_range && int'(r_s1_syndrome) == j + 1) w_fixed_block[j] = ~r_s1_block[j];
        end
    end

    // Stage 1: capture the codeword and its syndrome on input handshake.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_s1_valid    <= 1'b0;
            r_s1_block    <= '0;
            r_s1_syndrome <= '0;
        end else if (w_in_ready) begin
            r_s1_valid <= bus.in_valid;
            if (bus.in_valid) begin
                r_s1_block    <= bus.in_block;
                r_s1_syndrome <= calc_syndrome(bus.in_block);
            end
        end
    end

    // Stage 2: register corrected data and status; hold while stalled.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_s2_valid          <= 1'b0;
            r_out_data          <= '0;
            r_out_syndrome      <= '0;
            r_out_corrected     <= 1'b0;
            r_out_uncorrectable <= 1'b0;
        end else if (w_s2_en) begin
            r_s2_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_out_data          <= extract_data(w_fixed_block);
                r_out_syndrome      <= r_s1_syndrome;
                r_out_corrected     <= w_in_range;
                r_out_uncorrectable <= w_out_of_range;
            end
        end
    end

    // Saturating telemetry counters, bumped on output handshake; clear wins.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_corr_cnt   <= '0;
            r_uncorr_cnt <= '0;
        end else if (count_clear) begin
            r_corr_cnt   <= '0;
            r_uncorr_cnt <= '0;
        end else if (w_out_fire) begin
            if (r_out_corrected && r_corr_cnt != '1)       r_corr_cnt   <= r_corr_cnt + 1'b1;
            if (r_out_uncorrectable && r_uncorr_cnt != '1) r_uncorr_cnt <= r_uncorr_cnt + 1'b1;
        end
    end

    assign bus.in_ready          = w_in_ready;
    assign bus.out_valid         = r_s2_valid;
    assign bus.out_data          = r_out_data;
    assign bus.out_syndrome      = r_out_syndrome;
    assign bus.out_corrected     = r_out_corrected;
    assign bus.out_uncorrectable = r_out_uncorrectable;
    assign corrected_count       = r_corr_cnt;
    assign uncorrectable_count   = r_uncorr_cnt;

    logic w_unused;
    assign w_unused = w_in_fire;
endmodule

// File: tb/tb_hamming_corrector_pipeline.sv
// Scoreboard bench for hamming_corrector_pipeline: directed vectors, stall,
// counter saturation/clear, random error injection and mid-flight reset.
module tb_hamming_corrector_pipeline;
    localparam int DW = 8;
    localparam int PW = 4;
    localparam int BW = 12;
    localparam int CW = 4;
    localparam logic [CW-1:0] CMAX = '1;

    typedef struct {
        logic [DW-1:0] d;
        logic [PW-1:0] s;
        logic          c;
        logic          u;
    } exp_t;

    logic          clock;
    logic          resetn;
    logic          count_clear;
    logic [CW-1:0] corrected_count;
    logic [CW-1:0] uncorrectable_count;

    hamming_corrector_pipeline_if #(.DATA_WIDTH(DW)) bus();

    hamming_corrector_pipeline #(.DATA_WIDTH(DW), .COUNTER_WIDTH(CW)) dut (
        .clock               (clock),
        .resetn              (resetn),
        .bus                 (bus),
        .count_clear         (count_clear),
        .corrected_count     (corrected_count),
        .uncorrectable_count (uncorrectable_count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;

    exp_t          exp_q[$];
    logic [CW-1:0] m_corr = '0;
    logic [CW-1:0] m_unc  = '0;
    logic          stalled_prev = 1'b0;
    exp_t          held;
    logic          saw_in_ready_low = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // ---------------- reference model (position arithmetic) ----------------
    function automatic bit is_pow2(input int pos);
        return (pos & (pos - 1)) == 0;
    endfunction

    function automatic logic [BW-1:0] model_encode(input logic [DW-1:0] data);
        logic [BW-1:0] blk;
        int k, x;
        blk = '0; k = 0; x = 0;
        for (int pos = 1; pos <= BW; pos++) begin
            if (!is_pow2(pos)) begin
                blk[pos-1] = data[k];
                if (data[k]) x = x ^ pos;
                k++;
            end
        end
        for (int i = 0; i < PW; i++) blk[(1 << i) - 1] = (x >> i) & 1;
        return blk;
    endfunction

    function automatic int model_syndrome(input logic [BW-1:0] blk);
        int x;
        x = 0;
        for (int pos = 1; pos <= BW; pos++) if (blk[pos-1]) x = x ^ pos;
        return x;
    endfunction

    function automatic logic [DW-1:0] model_extract(input logic [BW-1:0] blk);
        logic [DW-1:0] d;
        int k;
        d = '0; k = 0;
        for (int pos = 1; pos <= BW; pos++) begin
            if (!is_pow2(pos)) begin
                d[k] = blk[pos-1];
                k++;
            end
        end
        return d;
    endfunction

    function automatic exp_t model_decode(input logic [BW-1:0] blk);
        exp_t e;
        int syn;
        logic [BW-1:0] b;
        syn = model_syndrome(blk);
        b = blk;
        e.s = syn[PW-1:0];
        e.c = 1'b0;
        e.u = 1'b0;
        if (syn >= 1 && syn <= BW) begin
            b[syn-1] = ~b[syn-1];
            e.c = 1'b1;
        end else if (syn > BW) begin
            e.u = 1'b1;
        end
        e.d = model_extract(b);
        return e;
    endfunction

    // ---------------- monitor / scoreboard ----------------
    always @(negedge clock) begin
        exp_t e;
        logic fire;
        if (resetn) begin
            if (stalled_prev && bus.out_valid) begin
                chk("stall_hold", {bus.out_data, bus.out_syndrome, bus.out_corrected, bus.out_uncorrectable},
                    {held.d, held.s, held.c, held.u});
            end
            fire = bus.out_valid && bus.out_ready;
            e.d = '0; e.s = '0; e.c = 1'b0; e.u = 1'b0;
            if (fire) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_beat", 32'd1, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    chk("out_beat", {bus.out_data, bus.out_syndrome, bus.out_corrected, bus.out_uncorrectable},
                        {e.d, e.s, e.c, e.u});
                end
            end
            chk("corrected_count", corrected_count, m_corr);
            chk("uncorrectable_count", uncorrectable_count, m_unc);
            if (count_clear) begin
                m_corr = '0;
                m_unc  = '0;
            end else if (fire) begin
                if (e.c && m_corr != CMAX) m_corr = m_corr + 1'b1;
                if (e.u && m_unc != CMAX)  m_unc  = m_unc + 1'b1;
            end
            stalled_prev = bus.out_valid && !bus.out_ready;
            held.d = bus.out_data;
            held.s = bus.out_syndrome;
            held.c = bus.out_corrected;
            held.u = bus.out_uncorrectable;
            if (!bus.in_ready) saw_in_ready_low = 1'b1;
        end
    end

    // ---------------- driver helpers (entered at posedge+1) ----------------
    task automatic send_beat(input logic [BW-1:0] blk, input exp_t e);
        bit done;
        done = 0;
        bus.in_valid = 1'b1;
        bus.in_block = blk;
        for (int n = 0; n < 50 && !done; n++) begin
            @(negedge clock);
            if (bus.in_ready) begin
                exp_q.push_back(e);
                done = 1;
            end
            @(posedge clock); #1;
        end
        if (!done) chk("accept_timeout", 32'd0, 32'd1);
        bus.in_valid = 1'b0;
    endtask

    task automatic drain();
        bit done;
        done = 0;
        for (int n = 0; n < 200 && !done; n++) begin
            @(posedge clock); #1;
            if (exp_q.size() == 0 && !bus.out_valid) done = 1;
        end
        if (!done) chk("drain_timeout", 32'd0, 32'd1);
    endtask

    function automatic exp_t mk(input logic [DW-1:0] d, input logic [PW-1:0] s, input logic c, input logic u);
        exp_t e;
        e.d = d; e.s = s; e.c = c; e.u = u;
        return e;
    endfunction

    bit rand_done;

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        resetn        = 1'b0;
        count_clear   = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_block  = '0;
        bus.out_ready = 1'b1;
        repeat (3) @(posedge clock);
        #1;
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_in_ready", bus.in_ready, 1);
        chk("rst_fields", {bus.out_data, bus.out_syndrome, bus.out_corrected, bus.out_uncorrectable}, 0);
        chk("rst_counters", {corrected_count, uncorrectable_count}, 0);
        resetn = 1'b1;
        @(posedge clock); #1;

        // Directed vectors
        send_beat(12'hA27, mk(8'hA5, 4'd0, 0, 0));
        drain();
        chk("clean_counts", {corrected_count, uncorrectable_count}, 0);
        send_beat(12'hA07, mk(8'hA5, 4'd6, 1, 0));
        drain();
        chk("corr_count_1", corrected_count, 1);
        send_beat(12'hB07, mk(8'hB1, 4'd15, 0, 1));
        drain();
        chk("unc_count_1", uncorrectable_count, 1);

        // Back-to-back stream with a 3-cycle downstream stall
        saw_in_ready_low = 1'b0;
        fork
            begin
                send_beat(12'hA27, mk(8'hA5, 4'd0, 0, 0));
                send_beat(12'hA07, mk(8'hA5, 4'd6, 1, 0));
                send_beat(12'hA26, mk(8'hA5, 4'd1, 1, 0));
            end
            begin
                repeat (2) begin @(posedge clock); #1; end
                bus.out_ready = 1'b0;
                repeat (3) begin @(posedge clock); #1; end
                bus.out_ready = 1'b1;
            end
        join
        drain();
        chk("in_ready_dropped", saw_in_ready_low, 1);

        // Saturation of corrected counter, then clear coincident with a handshake
        for (int i = 0; i < 16; i++) send_beat(12'hA07, mk(8'hA5, 4'd6, 1, 0));
        drain();
        chk("corr_saturated", corrected_count, CMAX);
        count_clear = 1'b1;
        send_beat(12'hA07, mk(8'hA5, 4'd6, 1, 0));
        drain();
        count_clear = 1'b0;
        chk("clear_priority", corrected_count, 0);

        // Random error injection with random backpressure and occasional clears
        rand_done = 0;
        fork
            begin
                for (int i = 0; i < 300; i++) begin
                    logic [DW-1:0] d;
                    logic [BW-1:0] blk;
                    int nflip, p1, p2;
                    d = DW'($urandom);
                    blk = model_encode(d);
                    nflip = $urandom_range(0, 2);
                    p1 = $urandom_range(0, BW - 1);
                    p2 = (p1 + $urandom_range(1, BW - 1)) % BW;
                    if (nflip >= 1) blk[p1] = ~blk[p1];
                    if (nflip == 2) blk[p2] = ~blk[p2];
                    send_beat(blk, model_decode(blk));
                    if ($urandom_range(0, 3) == 0) begin @(posedge clock); #1; end
                end
                rand_done = 1;
            end
            begin
                while (!rand_done) begin
                    @(posedge clock); #1;
                    bus.out_ready = ($urandom_range(0, 3) != 0);
                    count_clear   = ($urandom_range(0, 19) == 0);
                end
                bus.out_ready = 1'b1;
                count_clear   = 1'b0;
            end
        join
        drain();

        // Reset with both stages full
        bus.out_ready = 1'b0;
        send_beat(12'hA07, mk(8'hA5, 4'd6, 1, 0));
        send_beat(12'hB07, mk(8'hB1, 4'd15, 0, 1));
        @(posedge clock); #1;
        resetn = 1'b0;
        exp_q.delete();
        m_corr = '0;
        m_unc  = '0;
        stalled_prev = 1'b0;
        #1;
        chk("async_rst_out_valid", bus.out_valid, 0);
        chk("async_rst_counters", {corrected_count, uncorrectable_count}, 0);
        @(posedge clock); #1;
        resetn = 1'b1;
        bus.out_ready = 1'b1;
        for (int n = 0; n < 6; n++) begin
            @(posedge clock); #1;
            chk("no_stale_beat", bus.out_valid, 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/hamming_corrector_pipeline.md
Name: hamming_corrector_pipeline

Overview:
- Two-stage pipelined single-error-correcting Hamming decoder with valid/ready handshake.
- Sits directly downstream of the Hamming encoder, typically behind a storage or link stage. Consumes the encoder's BLOCK output and delivers corrected data.
- Reports per-beat error status and maintains saturating error counters for scrubbing and telemetry.

Parameters:
- DATA_WIDTH, 8, width of the payload data.
- PARITY_WIDTH, derived (localparam), smallest p with 2**p >= DATA_WIDTH+p+1; equals 4 for DATA_WIDTH=8.
- BLOCK_WIDTH, derived (localparam), DATA_WIDTH+PARITY_WIDTH.
- COUNTER_WIDTH, 16, width of each error counter.

Ports:
- clock  input  1  single clock, rising edge.
- resetn  input  1  asynchronous active-low reset.
- in_block  input  BLOCK_WIDTH  received codeword, encoder layout.
- in_valid  input  1  in_block valid.
- in_ready  output  1  stage 1 can accept.
- out_data  output  DATA_WIDTH  corrected data.
- out_syndrome  output  PARITY_WIDTH  syndrome of the beat.
- out_corrected  output  1  single-bit error was corrected.
- out_uncorrectable  output  1  syndrome out of range; data not corrected.
- out_valid  output  1  out_* valid.
- out_ready  input  1  downstream accepts.
- count_clear  input  1  synchronous clear of both counters.
- corrected_count  output  COUNTER_WIDTH  saturating count of corrected beats.
- uncorrectable_count  output  COUNTER_WIDTH  saturating count of uncorrectable beats.

Behaviour:
- Codeword layout (1-based position p = block index p-1):
  - Parity bit i sits at position 2**i.
  - Data bits fill the remaining positions in ascending order, d0 at position 3.
- Syndrome bit i = XOR of block[j] over all j with bit i of (j+1) set.
- Stage 1: on in_valid && in_ready, register in_block and its syndrome. s1_valid is set.
- Stage 2: on stage-1 advance, perform correction and register out_* fields. s2_valid drives out_valid.
  - syndrome == 0: data passes unchanged; both flags 0.
  - 1 <= syndrome <= BLOCK_WIDTH: invert block[syndrome-1], then extract data. out_corrected=1. A flipped parity bit still sets out_corrected; data is unaffected.
  - syndrome > BLOCK_WIDTH: extract data uncorrected. out_uncorrectable=1.
- Double errors that alias to an in-range syndrome are miscorrected and flagged only as corrected. No SECDED.
- Handshake and flow:
  - Stage 2 advance: s2_en = !s2_valid || out_ready.
  - in_ready = !s1_valid || s2_en, combinational, no combinational path from in_valid.
  - Latency: 2 cycles from accept to out_valid. Throughput 1 beat/cycle while out_ready=1.
  - out_* hold stable while out_valid && !out_ready. No beat is dropped or duplicated.
  - Bubbles collapse: a valid stage 1 advances into an empty stage 2 regardless of out_ready.
- Counters:
  - Increment on the output handshake (out_valid && out_ready) when the matching flag is set.
  - Saturate at all-ones.
  - count_clear in the same cycle as an increment yields 0; clear has priority.
- Reset:
  - All valids, out_* fields, counters and syndrome go to 0. in_ready is 1 after reset.
  - Reset asserted mid-transfer discards in-flight beats, with no output after deassertion.

Test Plan:
- DATA_WIDTH=8: in_block=0xA27 (encoding of 0xA5), out_ready=1 -> 2 cycles later out_data=0xA5, syndrome=0, flags 0, counters unchanged.
- in_block=0xA07 (bit 5 flipped) -> out_data=0xA5, out_syndrome=6, out_corrected=1; corrected_count 0->1 on handshake.
- in_block=0xB07 (bits 5 and 8 flipped) -> out_syndrome=15, out_uncorrectable=1, out_data=0xB1 (uncorrected); uncorrectable_count increments.
- Back-to-back stream of 0xA27, 0xA07, 0xA26 with out_ready low for 3 cycles mid-stream:
  - in_ready drops once both stages are full.
  - out_* remain stable while stalled.
  - Output order and values are preserved: 0xA5, 0xA5, 0xA5; the third beat flags syndrome=1, corrected.
- Preload corrected_count to all-ones via 2**16 corrected beats (or COUNTER_WIDTH=2 with 4 beats) -> holds at max; count_clear coincident with a corrected handshake -> counter 0.
- Assert resetn=0 with both stages valid -> out_valid=0 immediately (asynchronous), counters 0; after release, no stale beat appears.
